// File: rtl/imem_loader.sv
// Boot-time loader: takes a 4-byte big-endian length header plus payload over
// valid/ready and writes the payload bytes to instruction memory from BASE_ADDR.
module imem_loader #(
    parameter int unsigned ADDR_W    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        cpu_hold,
    output logic [7:0]  checksum
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [31:0] DEPTH = 32'(1) << ADDR_W;
    localparam logic [31:0] CAP   = DEPTH - BASE_ADDR;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_LOAD,
        S_FLUSH,
        S_DONE,
        S_ERR
    } state_e;

    state_e             state_q, state_d;
    logic [1:0]         hdr_cnt_q, hdr_cnt_d;
    logic [31:0]        len_q, len_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         csum_q, csum_d;
    logic               we_q, we_d;
    logic [31:0]        addr_q, addr_d;
    logic [7:0]         wdata_q, wdata_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
    logic               hold_q, hold_d;

    logic               accept;
    logic [31:0]        len_shift;

    assign accept    = in_valid && ready_q;
    assign len_shift = {len_q[23:0], in_data};

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            hdr_cnt_q <= 2'd0;
            len_q     <= 32'd0;
            cnt_q     <= '0;
            csum_q    <= 8'd0;
            we_q      <= 1'b0;
            addr_q    <= 32'd0;
            wdata_q   <= 8'd0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            hold_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            hdr_cnt_q <= hdr_cnt_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            csum_q    <= csum_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
            hold_q    <= hold_d;
        end
    end

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d   = state_q;
        hdr_cnt_d = hdr_cnt_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        csum_d    = csum_q;
        we_d      = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d   = S_HDR;
                    hdr_cnt_d = 2'd0;
                    cnt_d     = '0;
                    csum_d    = 8'd0;
                end
            end
            S_HDR: begin
                if (accept) begin
                    len_d     = len_shift;
                    hdr_cnt_d = hdr_cnt_q + 2'd1;
                    if (hdr_cnt_q == 2'd3) begin
                        if (len_shift == 32'd0)     state_d = S_DONE;
                        else if (len_shift > CAP)   state_d = S_ERR;
                        else                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (accept) begin
                    we_d    = 1'b1;
                    addr_d  = BASE_ADDR + 32'(cnt_q);
                    wdata_d = in_data;
                    csum_d  = csum_q + in_data;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (32'(cnt_q) + 32'd1 == len_q) state_d = S_FLUSH;
                end
            end
            S_FLUSH: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase

        // Status outputs are a pure function of the state being entered
        ready_d = (state_d == S_HDR) || (state_d == S_LOAD);
        busy_d  = ready_d || (state_d == S_FLUSH);
        done_d  = (state_d == S_DONE);
        error_d = (state_d == S_ERR);
        hold_d  = busy_d || error_d;
    end

    assign in_ready  = ready_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign cpu_hold  = hold_q;
    assign checksum  = csum_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: one instance at BASE_ADDR 0, one at 0x100.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst, start0, start1, in_valid;
    logic [7:0]  in_data;

    logic        rdy0, we0, busy0, done0, err0, hold0;
    logic [31:0] addr0;
    logic [7:0]  wd0, cs0;
    logic        rdy1, we1, busy1, done1, err1, hold1;
    logic [31:0] addr1;
    logic [7:0]  wd1, cs1;

    imem_loader #(.ADDR_W(10), .BASE_ADDR(32'h0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy0), .mem_we(we0), .mem_addr(addr0), .mem_wdata(wd0),
        .busy(busy0), .done(done0), .error(err0), .cpu_hold(hold0), .checksum(cs0)
    );

    imem_loader #(.ADDR_W(10), .BASE_ADDR(32'h100)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy1), .mem_we(we1), .mem_addr(addr1), .mem_wdata(wd1),
        .busy(busy1), .done(done1), .error(err1), .cpu_hold(hold1), .checksum(cs1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    // Memory model fed from the write ports, sampled mid-cycle
    logic [7:0]  mem0 [0:1023];
    logic [7:0]  mem1 [0:2047];
    int          wcnt0 = 0, wcnt1 = 0;
    logic [31:0] last_addr0 = 32'd0, last_addr1 = 32'd0;
    logic [7:0]  last_data0 = 8'd0;
    int          last_wcyc0 = 0;

    always @(negedge clk) begin
        if (we0) begin
            mem0[addr0[9:0]] = wd0;
            wcnt0            = wcnt0 + 1;
            last_addr0       = addr0;
            last_data0       = wd0;
            last_wcyc0       = cyc;
        end
        if (we1) begin
            mem1[addr1[10:0]] = wd1;
            wcnt1             = wcnt1 + 1;
            last_addr1        = addr1;
        end
    end

    logic [7:0] stream [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_sum();
        logic [7:0] s = 8'd0;
        for (int k = 4; k < stream.size(); k++) s = s + stream[k];
        return s;
    endfunction

    task automatic do_start(input int sel, output int s);
        if (sel == 1) start1 = 1'b1; else start0 = 1'b1;
        s = cyc;
        @(posedge clk); #1;
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    // Payload stalls insert one idle cycle before every payload byte; header is back-to-back
    task automatic send(input int sel, input bit stall, input int pulse_idx);
        int  i = 0;
        int  budget = 0;
        bit  rdy, v, xfer, idled = 1'b0;
        while (i < stream.size() && budget < 5000) begin
            rdy = (sel == 1) ? rdy1 : rdy0;
            if (stall && i >= 4 && !idled) begin
                v     = 1'b0;
                idled = 1'b1;
            end else begin
                v = 1'b1;
            end
            in_valid = v;
            in_data  = stream[i];
            start0   = (i == pulse_idx) && v;
            @(posedge clk); #1;
            start0 = 1'b0;
            xfer   = v && rdy;
            chk("we_cycle", {31'd0, (sel == 1) ? we1 : we0}, {31'd0, xfer && i >= 4});
            if (xfer) begin
                i++;
                idled = 1'b0;
            end
            budget++;
        end
        in_valid = 1'b0;
        if (budget >= 5000) chk("send_timeout", i, stream.size());
    endtask

    task automatic wait_end(input int sel, input int s, output int rel);
        int n = 0;
        while (!((sel == 1) ? (done1 || err1) : (done0 || err0)) && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        rel = cyc - s;
        if (n >= 3000) chk("wait_timeout", n, 0);
    endtask

    task automatic set_basic();
        stream = '{8'h00, 8'h00, 8'h00, 8'h08,
                   8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
    endtask

    task automatic check_basic(input string tag, input int s, input int w0, input int exp_done);
        int rel;
        wait_end(0, s, rel);
        chk({tag, "_done_cyc"}, rel, exp_done);
        chk({tag, "_writes"}, wcnt0 - w0, 8);
        chk({tag, "_word0"}, {mem0[0], mem0[1], mem0[2], mem0[3]}, 32'h1305_0000);
        chk({tag, "_word1"}, {mem0[4], mem0[5], mem0[6], mem0[7]}, 32'h9305_1000);
        chk({tag, "_csum"}, cs0, model_sum());
        chk({tag, "_flags"}, {28'd0, done0, busy0, hold0, err0}, 32'b1000);
    endtask

    initial begin
        int s, w0, w1, rel, bad;
        rst = 1'b1; start0 = 1'b0; start1 = 1'b0; in_valid = 1'b0; in_data = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctrl", {26'd0, rdy0, we0, busy0, done0, err0, hold0}, 32'd0);
        chk("rst_addr", addr0, 32'd0);
        chk("rst_data_csum", {16'd0, wd0, cs0}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic back-to-back load
        set_basic();
        w0 = wcnt0;
        do_start(0, s);
        send(0, 1'b0, -1);
        check_basic("basic", s, w0, 14);
        chk("basic_last_we_cyc", last_wcyc0 - s, 13);

        // Stalled producer
        w0 = wcnt0;
        do_start(0, s);
        send(0, 1'b1, -1);
        check_basic("stall", s, w0, 22);

        // Empty image
        stream = '{8'h00, 8'h00, 8'h00, 8'h00};
        w0 = wcnt0;
        do_start(0, s);
        send(0, 1'b0, -1);
        wait_end(0, s, rel);
        chk("empty_done_cyc", rel, 5);
        chk("empty_writes", wcnt0 - w0, 0);
        chk("empty_state", {22'd0, done0, err0, hold0, busy0, cs0}, {22'd0, 4'b1000, 8'h00});

        // Oversize image
        stream = '{8'h00, 8'h00, 8'h04, 8'h01};
        w0 = wcnt0;
        do_start(0, s);
        send(0, 1'b0, -1);
        wait_end(0, s, rel);
        chk("over_err_cyc", rel, 5);
        chk("over_flags", {27'd0, err0, hold0, busy0, done0, rdy0}, 32'b11000);
        chk("over_writes", wcnt0 - w0, 0);

        // Restart from ERR, full capacity image
        stream = '{8'h00, 8'h00, 8'h04, 8'h00};
        for (int k = 0; k < 1024; k++) stream.push_back(8'(k));
        w0 = wcnt0;
        do_start(0, s);
        chk("reerr_clear", {28'd0, err0, done0, busy0, hold0}, 32'b0011);
        send(0, 1'b0, -1);
        wait_end(0, s, rel);
        chk("full_done_cyc", rel, 1030);
        chk("full_writes", wcnt0 - w0, 1024);
        chk("full_last_addr", last_addr0, 32'd1023);
        chk("full_last_data", {24'd0, last_data0}, 32'hFF);
        chk("full_csum", cs0, model_sum());
        bad = 0;
        for (int k = 0; k < 1024; k++) if (mem0[k] !== 8'(k)) bad++;
        chk("full_contents", bad, 0);

        // start pulsed mid-LOAD has no effect
        set_basic();
        w0 = wcnt0;
        do_start(0, s);
        send(0, 1'b0, 6);
        check_basic("midstart", s, w0, 14);

        // Reset after three payload bytes
        stream = '{8'h00, 8'h00, 8'h00, 8'h08, 8'hAA, 8'hBB, 8'hCC};
        w0 = wcnt0;
        do_start(0, s);
        send(0, 1'b0, -1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_ctrl", {26'd0, rdy0, we0, busy0, done0, err0, hold0}, 32'd0);
        chk("abort_addr_data", {addr0[23:0], wd0}, 32'd0);
        chk("abort_csum", cs0, 8'd0);
        repeat (5) @(posedge clk);
        #1;
        chk("abort_writes", wcnt0 - w0, 3);
        chk("abort_mem2", mem0[2], 8'hCC);

        set_basic();
        w0 = wcnt0;
        do_start(0, s);
        send(0, 1'b0, -1);
        check_basic("after_abort", s, w0, 14);

        // Offset-base instance: load, then reload after DONE
        stream = '{8'h00, 8'h00, 8'h00, 8'h04, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        w1 = wcnt1;
        do_start(1, s);
        send(1, 1'b0, -1);
        wait_end(1, s, rel);
        chk("hi_done_cyc", rel, 10);
        chk("hi_writes", wcnt1 - w1, 4);
        chk("hi_word", {mem1[256], mem1[257], mem1[258], mem1[259]}, 32'hDEAD_BEEF);
        chk("hi_last_addr", last_addr1, 32'h103);
        chk("hi_csum", cs1, model_sum());

        stream = '{8'h00, 8'h00, 8'h00, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04};
        w1 = wcnt1;
        do_start(1, s);
        chk("hi_reload_clear", {23'd0, done1, err1, cs1}, 32'd0);
        send(1, 1'b0, -1);
        wait_end(1, s, rel);
        chk("hi2_done", {31'd0, done1}, 32'd1);
        chk("hi2_word", {mem1[256], mem1[257], mem1[258], mem1[259]}, 32'h0102_0304);
        chk("hi2_csum", cs1, 8'h0A);
        chk("hi2_writes", wcnt1 - w1, 4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
